// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle controller that decodes 16-bit instructions and sequences the
// register-file/ULA datapath through read, execute, writeback and response phases.
module datapath_sequencer #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] wd3,
  output logic [REG_AW-1:0] wa3,
  output logic              we3,
  output logic [REG_AW-1:0] ra1,
  output logic [REG_AW-1:0] ra2,
  output logic [2:0]        ULAControl,
  output logic              select_src,
  input  logic [DATA_W-1:0] ULAResult,
  input  logic              Z,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_z,
  output logic              resp_err,
  output logic [CNT_W-1:0]  retired_count
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, RESP} state_t;
  localparam logic [2:0] OP_LI = 3'b100, OP_ADDK = 3'b110, OP_BAD = 3'b111;
  state_t state, next;
  logic [2:0] op;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] result;
  logic z_q, err_q, accept, done;
  assign op     = instr[15:13];
  assign accept = instr_valid & instr_ready;
  assign done   = resp_valid & resp_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = (op == OP_LI) ? WB : (op == OP_BAD) ? RESP : READ;
      READ:    next = EXEC;
      EXEC:    next = WB;
      WB:      next = RESP;
      RESP:    if (done) next = IDLE;
      default: next = IDLE;
    endcase
  end
  // instr_ready is gated by rst so nothing is offered while reset is held
  always_comb begin
    instr_ready = rst & (state == IDLE);
    we3         = state == WB;
    resp_valid  = state == RESP;
    wa3         = rd_q;
    wd3         = result;
    resp_data   = result;
    resp_z      = z_q;
    resp_err    = err_q;
  end
  // Operand drives are loaded on acceptance so they are already valid during READ and hold afterwards
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_q          <= '0;
      result        <= '0;
      z_q           <= 1'b0;
      err_q         <= 1'b0;
      ra1           <= '0;
      ra2           <= '0;
      ULAControl    <= 3'b000;
      select_src    <= 1'b0;
      retired_count <= '0;
    end else begin
      if (accept) begin
        rd_q  <= REG_AW'(instr[12:10]);
        err_q <= op == OP_BAD;
        if (op == OP_LI) begin
          result <= DATA_W'(instr[7:0]);
          z_q    <= instr[7:0] == 8'd0;
        end else if (op == OP_BAD) begin
          result <= '0;
          z_q    <= 1'b0;
        end else begin
          ra1        <= REG_AW'(instr[9:7]);
          ra2        <= REG_AW'(instr[6:4]);
          ULAControl <= (op == OP_ADDK) ? 3'b000 : op;
          select_src <= op == OP_ADDK;
        end
      end
      if (state == EXEC) begin
        result <= ULAResult;
        z_q    <= Z;
      end
      if (done) begin
        err_q <= 1'b0;
        if (!err_q) retired_count <= retired_count + CNT_W'(1);
      end
    end
endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multi-cycle controller that takes encoded 16-bit instructions over a valid/ready handshake and sequences the 8-register, 8-bit register-file/ULA datapath. For each instruction it drives read addresses, ULA operation and source select, captures ULAResult/Z, writes the result back and returns a response. Sits between an instruction source (bench or future fetch unit) and the datapath, and is the sole driver of the datapath's wd3/wa3/we3/ra1/ra2/ULAControl/select_src.

Parameters:
DATA_W, 8, datapath word width
REG_AW, 3, register address width (8 registers)
CNT_W, 8, width of retired-instruction counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept instruction
instr  input  16  op[15:13], rd[12:10], rs1[9:7], rs2[6:4], imm8[7:0] (LI only)
wd3  output  DATA_W  register-file write data
wa3  output  REG_AW  register-file write address
we3  output  1  register-file write enable
ra1  output  REG_AW  read address A
ra2  output  REG_AW  read address B
ULAControl  output  3  ULA operation
select_src  output  1  0 = operand B from register file, 1 = constante
ULAResult  input  DATA_W  ULA result from datapath
Z  input  1  ULA zero flag from datapath
resp_valid  output  1  response available
resp_ready  input  1  response consumer ready
resp_data  output  DATA_W  value written to rd
resp_z  output  1  zero flag of resp_data
resp_err  output  1  illegal opcode, nothing written
retired_count  output  CNT_W  count of completed non-error instructions

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; instr_ready=0 while rst=0; all other outputs and internal registers 0; retired_count=0. Reset mid-instruction aborts it; we3 drops immediately; no write completes.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT (ULAControl = op, select_src=0); 110 ADDK (ULAControl=000, select_src=1, rs1 + constante); 100 LI (rd <- imm8, ULA unused); 111 illegal.
- States: IDLE, READ, EXEC, WB, RESP.
- IDLE: instr_ready=1. On instr_valid & instr_ready, latch instr. Next state: READ for ALU ops/ADDK, WB for LI, RESP with resp_err=1 for 111.
- READ: ra1=rs1, ra2=rs2, ULAControl/select_src as decoded. Datapath settles combinationally. Next: EXEC.
- EXEC: same drives held; capture ULAResult into result register and Z into z register at end of cycle. Next: WB.
- WB: we3=1 for exactly this cycle; wa3=rd; wd3=captured result (LI: imm8, z=(imm8==0)). Write occurs on the rising edge leaving WB. Next: RESP.
- RESP: resp_valid=1; resp_data/resp_z/resp_err stable until resp_valid & resp_ready. On that edge go to IDLE and increment retired_count when resp_err=0; counter wraps 2^CNT_W-1 -> 0. resp_err clears on leaving RESP.
- Latency from accept edge to resp_valid=1: ALU/ADDK 4 cycles, LI 2 cycles, illegal 1 cycle. With resp_ready held high, throughput is one instruction per 5 (ALU) / 3 (LI) / 2 (illegal) cycles.
- instr_ready=0 in every state except IDLE. instr is ignored outside IDLE; no back-to-back acceptance on the RESP->IDLE edge.
- we3=0 in every state except WB. ra1/ra2/ULAControl/select_src hold their last values outside READ/EXEC.
- rd=rs1 or rd=rs2 is legal; the operand is read before writeback.
- If resp_ready=1 is already high when RESP is entered, the response completes after one cycle.

Test Plan:
- Reset, then LI r1,0x02 and LI r2,0x02 -> each resp_valid after 2 cycles, resp_data=0x02, resp_z=0, one we3 pulse with wa3=1 then wa3=2, retired_count=2.
- ADD r3,r1,r2 -> ra1=1, ra2=2, ULAControl=000 in READ/EXEC, wd3=0x04 on wa3=3, resp_data=0x04, resp_z=0; then SUB r4,r1,r2 -> resp_data=0x00, resp_z=1.
- LI r7,0x03, then ADDK r5,r7 with constante=0x0C -> select_src=1, resp_data=0x0F; SLT r6,r7,r3 (3<4) -> resp_data=0x01.
- Illegal op 111 -> resp_err=1 after 1 cycle, we3 never asserts, retired_count unchanged.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data stay stable, instr_ready stays 0, a second instr_valid is not accepted until the handshake completes.
- Assert rst=0 during WB of ADD -> we3 drops asynchronously, destination register unchanged, retired_count=0, instr_ready=1 one cycle after release.
